qspi_tx_serializer: RTL and testbench

//  Downstream consumer of the 32-bit TX fifo. On a start pulse it pops words from the fifo
//  and shifts them MSB-first onto the QSPI IO lanes in single, dual or quad mode.
//  It generates SCLK (mode 0) and stalls with SCLK low whenever the fifo runs dry.
//  It sits between the TX fifo and the pad/IO mux of the flash controller.

---
 rtl/qspi_pkg.sv | 31 +++
 rtl/qspi_clk_div.sv | 48 ++++
 rtl/qspi_tx_serializer.sv | 159 +++++++++++++++
 tb/tb_qspi_tx_serializer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
`default_nettype none
// ============================================================
// Module   : qspi_pkg
// Brief    : Lane modes, FSM encoding and lane-width helper
// Revision : 1.0
// ============================================================
package qspi_pkg;

  localparam logic [1:0] LANE_SINGLE = 2'b00;
  localparam logic [1:0] LANE_DUAL   = 2'b01;
  localparam logic [1:0] LANE_QUAD   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Reserved mode 2'b11 falls back to single lane.
  function automatic logic [2:0] lane_width(input logic [1:0] mode);
    case (mode)
      LANE_DUAL: return 3'd2;
      LANE_QUAD: return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/qspi_clk_div.sv
`default_nettype none
// ============================================================
// Module   : qspi_clk_div
// Brief    : SCLK generator (mode 0) with edge strobes, idles low
// Revision : 1.0
// ============================================================
module qspi_clk_div #(
  parameter int DIV_HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall
);

  localparam int CNT_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV_HALF - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;
  logic             w_wrap;

  assign w_wrap = en && (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  // Strobes mark the clk cycle whose closing edge toggles sclk.
  assign sclk      = r_sclk;
  assign sclk_rise = w_wrap & ~r_sclk;
  assign sclk_fall = w_wrap &  r_sclk;

endmodule
`default_nettype wire

// File: rtl/qspi_tx_serializer.sv
`default_nettype none
// ============================================================
// Module   : qspi_tx_serializer
// Brief    : Pops TX fifo words and shifts them MSB-first onto QSPI lanes
// Revision : 1.0
// ============================================================
module qspi_tx_serializer
  import qspi_pkg::*;
#(
  parameter int DIV_HALF = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] byte_count,
  input  logic [1:0]       lane_mode,
  output logic             fifo_rd_en,
  input  logic [31:0]      fifo_rdata,
  input  logic             fifo_empty,
  output logic             sclk,
  output logic [3:0]       io_out,
  output logic [3:0]       io_oe,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_bytes_left;
  logic [5:0]       r_bits_left;
  logic [31:0]      r_shreg;
  logic             r_first_sent;
  logic [2:0]       w_width;
  logic             w_rd_en;
  logic             w_div_en;
  logic             w_sclk_rise;
  logic             w_sclk_fall;
  logic             w_word_end;

  assign w_width    = lane_width(r_mode);
  assign w_div_en   = (r_state == ST_SHIFT) && !abort;
  assign w_word_end = (r_state == ST_SHIFT) && w_sclk_fall &&
                      (r_bits_left == {3'b000, w_width});

  qspi_clk_div #(.DIV_HALF(DIV_HALF)) u_clk_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (w_div_en),
    .sclk      (sclk),
    .sclk_rise (w_sclk_rise),
    .sclk_fall (w_sclk_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = (byte_count == '0) ? ST_FINISH : ST_FETCH;
      end
      ST_FETCH: begin
        if (!fifo_empty) begin
          w_rd_en = 1'b1;
          w_next  = ST_LOAD;
        end
      end
      ST_LOAD:   w_next = ST_SHIFT;
      ST_SHIFT: begin
        if (w_word_end) w_next = (r_bytes_left == '0) ? ST_FINISH : ST_FETCH;
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    if (abort) begin
      w_next  = ST_IDLE;
      w_rd_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode       <= LANE_SINGLE;
      r_bytes_left <= '0;
      r_bits_left  <= '0;
      r_shreg      <= '0;
      r_first_sent <= 1'b0;
    end else if (abort) begin
      r_mode       <= LANE_SINGLE;
      r_bytes_left <= '0;
      r_bits_left  <= '0;
      r_shreg      <= '0;
      r_first_sent <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_bytes_left <= byte_count;
            r_mode       <= lane_mode;
            r_first_sent <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_shreg <= fifo_rdata;
          // A short tail word only carries its top bytes.
          if (r_bytes_left > CNT_W'(3)) begin
            r_bits_left  <= 6'd32;
            r_bytes_left <= r_bytes_left - CNT_W'(4);
          end else begin
            r_bits_left  <= {1'b0, r_bytes_left[1:0], 3'b000};
            r_bytes_left <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_sclk_rise) r_first_sent <= 1'b1;
          if (w_sclk_fall) begin
            r_shreg     <= r_shreg << w_width;
            r_bits_left <= r_bits_left - {3'b000, w_width};
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign busy       = (r_state == ST_FETCH) || (r_state == ST_LOAD) || (r_state == ST_SHIFT);
  assign stall      = (r_state == ST_FETCH) && fifo_empty && r_first_sent;
  assign done       = (r_state == ST_FINISH);

  always_comb begin
    io_out = 4'b0000;
    io_oe  = 4'b0000;
    if ((r_state == ST_SHIFT) || stall) begin
      case (w_width)
        3'd2:    io_oe = 4'b0011;
        3'd4:    io_oe = 4'b1111;
        default: io_oe = 4'b0001;
      endcase
    end
    if (r_state == ST_SHIFT) begin
      case (w_width)
        3'd2:    io_out = {2'b00, r_shreg[31:30]};
        3'd4:    io_out = r_shreg[31:28];
        default: io_out = {3'b000, r_shreg[31]};
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qspi_tx_serializer.sv
`default_nettype none
// ============================================================
// Module   : tb_qspi_tx_serializer
// Brief    : Directed self-checking bench for qspi_tx_serializer
// Revision : 1.0
// ============================================================
module tb_qspi_tx_serializer;

  localparam int DIV_HALF = 2;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] byte_count = '0;
  logic [1:0]       lane_mode = 2'b00;
  logic             fifo_rd_en;
  logic [31:0]      fifo_rdata = 32'h0;
  logic             fifo_empty;
  logic             sclk;
  logic [3:0]       io_out;
  logic [3:0]       io_oe;
  logic             busy;
  logic             stall;
  logic             done;

  qspi_tx_serializer #(.DIV_HALF(DIV_HALF), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .byte_count (byte_count),
    .lane_mode  (lane_mode),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .sclk       (sclk),
    .io_out     (io_out),
    .io_oe      (io_oe),
    .busy       (busy),
    .stall      (stall),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Fifo model: data appears the cycle after the pop.
  logic [31:0] mem [0:31];
  logic [4:0]  wr_ptr = 5'd0;
  logic [4:0]  rd_ptr = 5'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 5'd1;
    end
  end

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 5'd1;
  endtask

  // Bus monitor, sampled mid-cycle.
  int         rises = 0, rd_cnt = 0, done_cnt = 0, stall_cyc = 0, stall_bad = 0;
  logic       prev_sclk = 1'b0;
  logic [3:0] cap_io [0:1023];
  logic [3:0] cap_oe [0:1023];

  always @(negedge clk) begin
    if (sclk && !prev_sclk) begin
      cap_io[rises % 1024] = io_out;
      cap_oe[rises % 1024] = io_oe;
      rises++;
    end
    prev_sclk = sclk;
    if (fifo_rd_en) rd_cnt++;
    if (done) done_cnt++;
    if (stall) begin
      stall_cyc++;
      if (sclk || io_oe != 4'hF) stall_bad++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_w [0:3];
  int b_rise, b_rd, b_done;
  int cur_w, cur_bytes;
  logic [1:0] cur_mode;

  task automatic begin_xfer(input logic [1:0] mode, input int nbytes);
    b_rise    = rises;
    b_rd      = rd_cnt;
    b_done    = done_cnt;
    cur_mode  = mode;
    cur_bytes = nbytes;
    cur_w     = (mode == 2'b10) ? 4 : (mode == 2'b01) ? 2 : 1;
    @(negedge clk);
    start      = 1'b1;
    byte_count = CNT_W'(nbytes);
    lane_mode  = mode;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic end_xfer(input string tag);
    int          nr;
    logic [127:0] g_io, e_io, g_oe, e_oe;
    logic [3:0]  mask;
    nr   = 8 * cur_bytes / cur_w;
    mask = (cur_mode == 2'b10) ? 4'hF : (cur_mode == 2'b01) ? 4'h3 : 4'h1;
    for (int c = 0; c < 3000 && done_cnt == b_done; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    g_io = '0; e_io = '0; g_oe = '0; e_oe = '0;
    for (int k = 0; k < nr; k++) begin
      int          pos;
      logic [31:0] wd;
      logic [31:0] bits;
      pos  = k * cur_w;
      wd   = exp_w[pos / 32];
      bits = (wd >> (32 - (pos % 32) - cur_w)) & ((32'd1 << cur_w) - 32'd1);
      g_io = {g_io[123:0], cap_io[(b_rise + k) % 1024]};
      e_io = {e_io[123:0], bits[3:0]};
      g_oe = {g_oe[123:0], cap_oe[(b_rise + k) % 1024]};
      e_oe = {e_oe[123:0], mask};
    end
    check({tag, "_done"},  128'(done_cnt - b_done), 128'd1);
    check({tag, "_rd"},    128'(rd_cnt - b_rd),     128'((cur_bytes + 3) / 4));
    check({tag, "_rises"}, 128'(rises - b_rise),    128'(nr));
    check({tag, "_data"},  g_io, e_io);
    check({tag, "_oe"},    g_oe, e_oe);
    check({tag, "_idle"},  128'({busy, sclk, io_oe}), 128'd0);
  endtask

  task automatic wait_rises(input int n, input string tag);
    for (int c = 0; c < 500 && rises < b_rise + n; c++) @(negedge clk);
    check({tag, "_reach"}, 128'(rises - b_rise >= n), 128'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outs", 128'({sclk, io_out, io_oe, busy, stall, done, fifo_rd_en}), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset", 128'({sclk, busy, done, fifo_rd_en}), 128'd0);

    // 1: quad, 4 bytes, with a start pulse during the transfer
    push(32'hA5C30F81);
    exp_w[0] = 32'hA5C30F81;
    begin_xfer(2'b10, 4);
    repeat (5) @(negedge clk);
    start = 1'b1; byte_count = CNT_W'(8); lane_mode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    end_xfer("quad4");

    // 2: single, 1 byte; rest of word dropped
    push(32'h80000000);
    exp_w[0] = 32'h80000000;
    begin_xfer(2'b00, 1);
    end_xfer("single1");

    // 3: dual, 6 bytes across two words
    push(32'h11223344);
    push(32'h5566AAAA);
    exp_w[0] = 32'h11223344;
    exp_w[1] = 32'h5566AAAA;
    begin_xfer(2'b01, 6);
    end_xfer("dual6");

    // 4: quad, 8 bytes, fifo runs dry between words
    push(32'hDEADBEEF);
    exp_w[0] = 32'hDEADBEEF;
    exp_w[1] = 32'h01234567;
    begin_xfer(2'b10, 8);
    for (int c = 0; c < 500 && !stall; c++) @(negedge clk);
    begin
      int s0;
      s0 = stall_cyc;
      repeat (20) @(negedge clk);
      check("stall_held", 128'(stall_cyc - s0 >= 19), 128'd1);
    end
    push(32'h01234567);
    end_xfer("quad8_gap");
    check("stall_sclk_oe", 128'(stall_bad), 128'd0);

    // 5: zero-length start
    b_rise = rises; b_rd = rd_cnt; b_done = done_cnt;
    start = 1'b1; byte_count = '0; lane_mode = 2'b10;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", 128'({done, busy}), 128'b10);
    @(negedge clk);
    check("zero_done_end", 128'(done), 128'd0);
    repeat (5) @(negedge clk);
    check("zero_quiet", 128'({32'(rd_cnt - b_rd), 32'(rises - b_rise), 32'(done_cnt - b_done)}),
          {32'd0, 32'd0, 32'd0, 32'd1});

    // 6a: abort after 3 rises, then restart from next word
    push(32'hA5C30F81);
    push(32'h12345678);
    begin_xfer(2'b10, 4);
    wait_rises(3, "abort");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_outs", 128'({sclk, io_oe, busy}), 128'd0);
    repeat (10) @(negedge clk);
    check("abort_nodone", 128'({32'(done_cnt - b_done), 32'(rd_cnt - b_rd)}), {32'd0, 32'd1});
    exp_w[0] = 32'h12345678;
    begin_xfer(2'b10, 4);
    end_xfer("after_abort");

    // 6b: reset after 3 rises, then restart from next word
    push(32'hDEADBEEF);
    push(32'hCAFEF00D);
    begin_xfer(2'b10, 4);
    wait_rises(3, "reset");
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_outs", 128'({sclk, io_oe, busy, fifo_rd_en}), 128'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_nodone", 128'({32'(done_cnt - b_done), 32'(rd_cnt - b_rd)}), {32'd0, 32'd1});
    exp_w[0] = 32'hCAFEF00D;
    begin_xfer(2'b10, 4);
    end_xfer("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
